vedic_seq_mult4x4: RTL
======================

VEDIC_SEQ_MULT4X4 -- requirements
Module: vedic_seq_mult4x4

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  4  unsigned multiplicand.
REQ-007 b  input  4  unsigned multiplier.
REQ-008 out_valid  output  1  product valid; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts product.
REQ-010 product  output  8  unsigned a*b.
REQ-011 busy  output  1  high in CALC or DONE.

Function
REQ-012 The block SHALL compute the 8-bit product by Vedic decomposition: one shared 2x2 multiplier stage, one 2-bit slice pair per cycle.
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 IDLE: when in_valid and in_ready are high, the block SHALL capture a and b, clear the accumulator, set step to 0 and go to CALC.
REQ-015 CALC: step counter 2 bits, 0..3; per step the accumulator SHALL add a partial product:
- step0: a[1:0]*b[1:0], shifted left 0
- step1: a[3:2]*b[1:0], shifted left 2
- step2: a[1:0]*b[3:2], shifted left 2
- step3: a[3:2]*b[3:2], shifted left 4
REQ-016 Accumulator SHALL be 8 bits; overflow is impossible (max 225); no saturation logic.
REQ-017 At step 3 the final sum SHALL load into product and the FSM SHALL go to DONE.
REQ-018 Latency: out_valid SHALL first be high on the 5th rising edge after the accepting edge.
REQ-019 DONE: product and out_valid SHALL hold stable until out_ready is high; on that edge the FSM SHALL go to IDLE and out_valid SHALL drop.
REQ-020 in_valid during CALC/DONE SHALL be ignored; operands are not queued.
REQ-021 product SHALL keep its last value in IDLE until the next completion overwrites it.
REQ-022 Captured operands SHALL be unaffected by changes on a/b after acceptance.

Reset
REQ-023 rst_n low, at any time including mid-CALC or DONE:
- state to IDLE; step, accumulator, product, out_valid and busy to 0; in_ready to 1
- any in-flight result is discarded
REQ-024 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro VEDIC_SEQ_ZERO_SKIP_EN.
- Defined: in IDLE, if an accepted a or b equals 0, the FSM SHALL go directly to DONE with product 0; out_valid is high 1 edge after acceptance.
- Undefined: all operands take the full 4-step CALC path.
- Result values SHALL be identical in both builds.

Structure
REQ-026 Shared package vedic_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE), the operand width constant (4) and the product width constant (8).
REQ-027 The partial product SHALL come from one instance of the existing 2x2 Vedic multiplier sub-module, Multiplier2x2, driven by muxed 2-bit slices; no other sub-modules.

Verification
REQ-028 a=13, b=11, out_ready=1 -> product=0x8F, out_valid exactly 5 edges after acceptance, 1 cycle wide.
REQ-029 a=15, b=15 -> product=0xE1; exhaustive sweep of all 256 pairs matches a*b.
REQ-030 a=0, b=9 -> product=0x00; out_valid after 1 edge with VEDIC_SEQ_ZERO_SKIP_EN, after 5 edges without it.
REQ-031 a=7, b=6, out_ready held low for 10 cycles -> product=0x2A and out_valid stable throughout; IDLE on the edge where out_ready rises.
REQ-032 rst_n pulsed low during step 2 of a=9, b=9 -> all outputs 0 and in_ready=1 immediately; a following a=3, b=5 yields 0x0F.
REQ-033 in_valid with a=2, b=2 asserted during CALC of a=4, b=4 -> only 0x10 is produced; the second pair is not accepted.

Source files
------------

// File: rtl/vedic_pkg.sv
// -----------------------------------------------------------------------------
// vedic_pkg
// Shared types and constants for the sequential 4x4 Vedic multiplier.
//   state_t   : controller states (IDLE / CALC / DONE)
//   OPND_W    : operand width (4)
//   PROD_W    : product width (8)
//   SLICE_W   : width of one operand slice fed to the 2x2 core (2)
//   PP_W      : width of one 2x2 partial product (4)
//   align_pp  : places a partial product at the weight of the current step
// -----------------------------------------------------------------------------
package vedic_pkg;

   localparam int OPND_W  = 4;
   localparam int PROD_W  = 8;
   localparam int SLICE_W = 2;
   localparam int PP_W    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Step order is lo*lo, hi*lo, lo*hi, hi*hi, so the two cross terms
   // share weight 4 and the hi*hi term carries weight 16.
   function automatic logic [PROD_W-1:0] align_pp(input logic [PP_W-1:0] pp,
                                                  input logic [1:0]      step);
      logic [PROD_W-1:0] ext;
      logic [PROD_W-1:0] res;
      ext = {{(PROD_W-PP_W){1'b0}}, pp};
      case (step)
         2'd0:    res = ext;
         2'd1:    res = ext << 2;
         2'd2:    res = ext << 2;
         default: res = ext << 4;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/Multiplier2x2.sv
// -----------------------------------------------------------------------------
// Multiplier2x2
// Combinational 2x2 Vedic (Urdhva-Tiryakbhyam) multiplier.
//   a [1:0] : multiplicand slice
//   b [1:0] : multiplier slice
//   p [3:0] : unsigned product a*b
// -----------------------------------------------------------------------------
module Multiplier2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);

   logic cross_a;
   logic cross_b;
   logic carry_1;
   logic high_and;

   // Vertical and crosswise terms; the only carry comes from the cross pair.
   assign cross_a  = a[1] & b[0];
   assign cross_b  = a[0] & b[1];
   assign carry_1  = cross_a & cross_b;
   assign high_and = a[1] & b[1];

   assign p[0] = a[0] & b[0];
   assign p[1] = cross_a ^ cross_b;
   assign p[2] = high_and ^ carry_1;
   assign p[3] = high_and & carry_1;

endmodule

// File: rtl/vedic_seq_mult4x4.sv
// -----------------------------------------------------------------------------
// vedic_seq_mult4x4
// Sequential 4x4 unsigned multiplier built from a single shared 2x2 Vedic
// core. One pair of 2-bit slices is multiplied per CALC cycle and summed into
// an 8-bit accumulator; the result is held in DONE until the consumer takes it.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand pair a/b presented
//   in_ready   : operands accepted (high only in IDLE)
//   a, b [3:0] : unsigned operands
//   out_valid  : product valid (high only in DONE)
//   out_ready  : consumer accepts product
//   product    : unsigned a*b, held until the next completion
//   busy       : high in CALC or DONE
//
// Build option
//   VEDIC_SEQ_ZERO_SKIP_EN : when defined, an accepted pair with a zero
//   operand bypasses CALC and goes straight to DONE with product 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for in_valid; operands captured on acceptance
// CALC  | one partial product per cycle, step 0..3, result loaded at 3
// DONE  | product presented, held until out_ready
// -----------------------------------------------------------------------------
module vedic_seq_mult4x4
   import vedic_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  a,
   input  logic [3:0]  b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  product,
   output logic        busy
);

   state_t               state_q;
   state_t               state_d;

   logic [1:0]           step_q;
   logic [OPND_W-1:0]    a_q;
   logic [OPND_W-1:0]    b_q;
   logic [PROD_W-1:0]    acc_q;
   logic [PROD_W-1:0]    product_q;

   logic                 accept;
   logic                 skip;
   logic                 last_step;
   logic [SLICE_W-1:0]   slice_a;
   logic [SLICE_W-1:0]   slice_b;
   logic [PP_W-1:0]      pp;
   logic [PROD_W-1:0]    pp_aligned;
   logic [PROD_W-1:0]    acc_sum;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
   assign skip = (a == '0) || (b == '0);
`else
   assign skip = 1'b0;
`endif

   assign last_step = (step_q == 2'd3);

   // step[0] selects the high half of a, step[1] the high half of b, which
   // walks lo*lo, hi*lo, lo*hi, hi*hi.
   assign slice_a = step_q[0] ? a_q[3:2] : a_q[1:0];
   assign slice_b = step_q[1] ? b_q[3:2] : b_q[1:0];

   Multiplier2x2 u_mul2x2 (
      .a (slice_a),
      .b (slice_b),
      .p (pp)
   );

   assign pp_aligned = align_pp(pp, step_q);
   // Largest possible sum is 15*15 = 225, so 8 bits never overflow.
   assign acc_sum    = acc_q + pp_aligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = skip ? DONE : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (last_step) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q    <= 2'd0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q    <= a;
                  b_q    <= b;
                  acc_q  <= '0;
                  step_q <= 2'd0;
                  if (skip) begin
                     product_q <= '0;
                  end
               end
            end
            CALC: begin
               acc_q  <= acc_sum;
               step_q <= step_q + 2'd1;
               if (last_step) begin
                  product_q <= acc_sum;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign product = product_q;

endmodule
